// File: rtl/prach_pkg.sv
// Shared types for the PRACH TDM slot aligner.
// Holds the lock FSM encoding and the error counter width.
package prach_pkg;

  localparam int ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/prach_tdm_align_if.sv
// Bundle of the aligner data/slot/status signals.
// master drives samples upstream-side, slave is the aligner view.
interface prach_tdm_align_if #(
  parameter int NUM_CC = 3,
  parameter int DW     = 16,
  parameter int CHN_W  = 3
);

  logic [NUM_CC-1:0][DW-1:0] din_dr;
  logic [NUM_CC-1:0][DW-1:0] din_di;
  logic [CHN_W-1:0]          din_chn;
  logic                      sync_in;
  logic                      err_clr;

  logic [NUM_CC-1:0][DW-1:0] dout_dr;
  logic [NUM_CC-1:0][DW-1:0] dout_di;
  logic [CHN_W-1:0]          dout_chn;
  logic                      dout_valid;
  logic                      sync_out;
  logic                      align_err;
  logic                      chn_err;
  logic [15:0]               err_cnt;

  modport master (
    output din_dr, din_di, din_chn,
    output sync_in, err_clr,
    input  dout_dr, dout_di, dout_chn,
    input  dout_valid, sync_out,
    input  align_err, chn_err, err_cnt
  );

  modport slave (
    input  din_dr, din_di, din_chn,
    input  sync_in, err_clr,
    output dout_dr, dout_di, dout_chn,
    output dout_valid, sync_out,
    output align_err, chn_err, err_cnt
  );

endinterface

// File: rtl/prach_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Clear beats increment; the count sticks at all-ones.
import prach_pkg::*;

module prach_sat_cnt #(
  parameter int W = ERR_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/prach_tdm_align.sv
// Realigns a TDM slot index to a frame sync and retimes I/Q.
// Lock FSM tracks slot continuity and flags phase/sequence errors.
import prach_pkg::*;

module prach_tdm_align #(
  parameter  int NUM_CC   = 3,
  parameter  int DW       = 16,
  parameter  int NUM_SLOT = 8,
  localparam int CHN_W    = $clog2(NUM_SLOT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CC-1:0][DW-1:0] din_dr,
  input  logic [NUM_CC-1:0][DW-1:0] din_di,
  input  logic [CHN_W-1:0]          din_chn,
  input  logic                      sync_in,
  input  logic                      err_clr,
  output logic [NUM_CC-1:0][DW-1:0] dout_dr,
  output logic [NUM_CC-1:0][DW-1:0] dout_di,
  output logic [CHN_W-1:0]          dout_chn,
  output logic                      dout_valid,
  output logic                      sync_out,
  output logic                      align_err,
  output logic                      chn_err,
  output logic [ERR_CNT_W-1:0]      err_cnt
);

  localparam logic [CHN_W-1:0] CHN_LAST = CHN_W'(NUM_SLOT - 1);

  state_e                    state_q, state_d;
  logic [CHN_W-1:0]          chn_q, chn_d;
  logic                      valid_q, valid_d;
  logic                      sync_q, sync_d;
  logic                      aerr_q, aerr_d;
  logic                      cerr_q, cerr_d;
  logic [NUM_CC-1:0][DW-1:0] dr_q, di_q;

  logic             din_zero;
  logic             trig;
  logic [CHN_W-1:0] chn_inc;

  assign din_zero = (din_chn == '0);
  assign trig     = sync_in && din_zero;
  assign chn_inc  = chn_q + CHN_W'(1);

  always_comb begin
    state_d = state_q;
    chn_d   = chn_inc;
    sync_d  = 1'b0;
    aerr_d  = 1'b0;
    cerr_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_LOCKED;
          chn_d   = '0;
          sync_d  = 1'b1;
        end else if (sync_in) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (din_zero) begin
          state_d = ST_LOCKED;
          chn_d   = '0;
          sync_d  = 1'b1;
        end
      end
      ST_LOCKED: begin
        // a sync always outranks the continuity check
        if (trig) begin
          sync_d = 1'b1;
          if (chn_q != CHN_LAST) begin
            chn_d  = '0;
            aerr_d = 1'b1;
          end
        end else if (sync_in) begin
          state_d = ST_PEND;
        end else if (din_chn != chn_inc) begin
          state_d = ST_IDLE;
          cerr_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    valid_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      chn_q   <= '0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      aerr_q  <= 1'b0;
      cerr_q  <= 1'b0;
      dr_q    <= '0;
      di_q    <= '0;
    end else begin
      state_q <= state_d;
      chn_q   <= chn_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
      aerr_q  <= aerr_d;
      cerr_q  <= cerr_d;
      dr_q    <= din_dr;
      di_q    <= din_di;
    end
  end

  // fed from next-state pulses so the count lands with the flag
  prach_sat_cnt #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (aerr_d | cerr_d),
    .clr   (err_clr),
    .cnt   (err_cnt)
  );

  assign dout_dr    = dr_q;
  assign dout_di    = di_q;
  assign dout_chn   = chn_q;
  assign dout_valid = valid_q;
  assign sync_out   = sync_q;
  assign align_err  = aerr_q;
  assign chn_err    = cerr_q;

endmodule

// File: tb/tb_prach_tdm_align.sv
// Scoreboard bench for prach_tdm_align against a slot-lock model.
// Extra instances cover the narrow and wide data builds.
module tb_prach_tdm_align;

  localparam int NS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prach_tdm_align_if #(.NUM_CC(3), .DW(16), .CHN_W(3)) ifc ();

  prach_tdm_align #(.NUM_CC(3), .DW(16), .NUM_SLOT(NS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_dr     (ifc.din_dr),
    .din_di     (ifc.din_di),
    .din_chn    (ifc.din_chn),
    .sync_in    (ifc.sync_in),
    .err_clr    (ifc.err_clr),
    .dout_dr    (ifc.dout_dr),
    .dout_di    (ifc.dout_di),
    .dout_chn   (ifc.dout_chn),
    .dout_valid (ifc.dout_valid),
    .sync_out   (ifc.sync_out),
    .align_err  (ifc.align_err),
    .chn_err    (ifc.chn_err),
    .err_cnt    (ifc.err_cnt)
  );

  logic [0:0][11:0] d1_dr, d1_di, q1_dr, q1_di;
  logic [2:0]       u1_chn;
  logic             u1_v, u1_s, u1_a, u1_c;
  logic [15:0]      u1_cnt;

  prach_tdm_align #(.NUM_CC(1), .DW(12), .NUM_SLOT(NS)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_dr     (d1_dr),
    .din_di     (d1_di),
    .din_chn    (ifc.din_chn),
    .sync_in    (ifc.sync_in),
    .err_clr    (ifc.err_clr),
    .dout_dr    (q1_dr),
    .dout_di    (q1_di),
    .dout_chn   (u1_chn),
    .dout_valid (u1_v),
    .sync_out   (u1_s),
    .align_err  (u1_a),
    .chn_err    (u1_c),
    .err_cnt    (u1_cnt)
  );

  logic [7:0][17:0] d8_dr, d8_di, q8_dr, q8_di;
  logic [2:0]       u8_chn;
  logic             u8_v, u8_s, u8_a, u8_c;
  logic [15:0]      u8_cnt;

  prach_tdm_align #(.NUM_CC(8), .DW(18), .NUM_SLOT(NS)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_dr     (d8_dr),
    .din_di     (d8_di),
    .din_chn    (ifc.din_chn),
    .sync_in    (ifc.sync_in),
    .err_clr    (ifc.err_clr),
    .dout_dr    (q8_dr),
    .dout_di    (q8_di),
    .dout_chn   (u8_chn),
    .dout_valid (u8_v),
    .sync_out   (u8_s),
    .align_err  (u8_a),
    .chn_err    (u8_c),
    .err_cnt    (u8_cnt)
  );

  typedef struct {
    logic [47:0]  dr, di;
    logic [11:0]  dr1, di1;
    logic [143:0] dr8, di8;
    logic [2:0]   chn;
    logic         valid, sync, ae, ce;
    logic [15:0]  cnt;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // model state: 0 idle, 1 waiting for slot 0, 2 locked
  int m_st = 0;
  int m_chn = 0;
  int m_cnt = 0;
  int up = 0;

  task automatic chk(input string nm, input logic [159:0] a,
                     input logic [159:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, x, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0;
    m_chn = 0;
    m_cnt = 0;
  endtask

  task automatic step(input bit s, input int c, input bit clr);
    exp_t e;
    bit trig;
    int nxt;
    for (int i = 0; i < 3; i++) begin
      ifc.din_dr[i] = 16'($urandom);
      ifc.din_di[i] = 16'($urandom);
    end
    d1_dr[0] = 12'($urandom);
    d1_di[0] = 12'($urandom);
    for (int i = 0; i < 8; i++) begin
      d8_dr[i] = 18'($urandom);
      d8_di[i] = 18'($urandom);
    end
    ifc.sync_in = s;
    ifc.din_chn = 3'(c);
    ifc.err_clr = clr;
    e.dr = 48'(ifc.din_dr);
    e.di = 48'(ifc.din_di);
    e.dr1 = 12'(d1_dr);
    e.di1 = 12'(d1_di);
    e.dr8 = 144'(d8_dr);
    e.di8 = 144'(d8_di);
    e.sync = 0;
    e.ae = 0;
    e.ce = 0;
    trig = s && (c == 0);
    nxt = (m_chn + 1) % NS;
    if (m_st == 0) begin
      if (trig) begin
        m_st = 2; nxt = 0; e.sync = 1;
      end else if (s) m_st = 1;
    end else if (m_st == 1) begin
      if (c == 0) begin
        m_st = 2; nxt = 0; e.sync = 1;
      end
    end else begin
      if (trig) begin
        e.sync = 1;
        if (m_chn != NS - 1) begin
          nxt = 0; e.ae = 1;
        end
      end else if (s) m_st = 1;
      else if (c != nxt) begin
        m_st = 0; e.ce = 1;
      end
    end
    m_chn = nxt;
    if (clr) m_cnt = 0;
    else if ((e.ae || e.ce) && m_cnt < 65535) m_cnt++;
    e.chn = 3'(m_chn);
    e.valid = (m_st == 2);
    e.cnt = 16'(m_cnt);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, up, 0);
      up = (up + 1) % NS;
    end
  endtask

  task automatic go_to(input int v);
    for (int i = 0; i < NS && up != v; i++) adv(1);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("dout_dr", 160'(ifc.dout_dr), 160'(e.dr));
      chk("dout_di", 160'(ifc.dout_di), 160'(e.di));
      chk("cc1_data", 160'({q1_dr, q1_di}), 160'({e.dr1, e.di1}));
      chk("cc8_data", 160'(q8_dr), 160'(e.dr8));
      chk("cc8_data_i", 160'(q8_di), 160'(e.di8));
      chk("dout_chn", 160'(ifc.dout_chn), 160'(e.chn));
      chk("dout_valid", 160'(ifc.dout_valid), 160'(e.valid));
      chk("sync_out", 160'(ifc.sync_out), 160'(e.sync));
      chk("align_err", 160'(ifc.align_err), 160'(e.ae));
      chk("chn_err", 160'(ifc.chn_err), 160'(e.ce));
      chk("err_cnt", 160'(ifc.err_cnt), 160'(e.cnt));
    end
  end

  initial begin
    ifc.din_dr = '0;
    ifc.din_di = '0;
    ifc.din_chn = '0;
    ifc.sync_in = 1'b0;
    ifc.err_clr = 1'b0;
    d1_dr = '0;
    d1_di = '0;
    d8_dr = '0;
    d8_di = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 160'(ifc.dout_valid), 160'(0));
    chk("rst_cnt", 160'(ifc.err_cnt), 160'(0));
    rst_n = 1'b1;
    model_reset();

    up = 5;
    adv(3);
    step(1, 0, 0);
    up = 1;
    adv(20);

    go_to(4);
    step(1, 0, 0);
    up = 1;
    adv(10);

    go_to(4);
    adv(1);
    step(0, 6, 1);
    up = 7;

    go_to(5);
    step(1, 5, 0);
    up = 6;
    adv(3);
    adv(10);

    go_to(3);
    step(1, 3, 0);
    up = 4;
    adv(8);

    for (int i = 0; i < 400; i++) begin
      int r;
      bit s, clr;
      r = $urandom_range(99);
      s = (r < 6);
      if (r >= 95) up = $urandom_range(NS - 1);
      clr = ($urandom_range(49) == 0);
      step(s, up, clr);
      up = (up + 1) % NS;
    end

    for (int i = 0; i < 70010; i++) step(1, 0, 0);
    chk("sat_cnt", 160'(ifc.err_cnt), 160'(16'hffff));

    step(1, 3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 160'(ifc.dout_valid), 160'(0));
    chk("arst_sync", 160'(ifc.sync_out), 160'(0));
    chk("arst_aerr", 160'(ifc.align_err), 160'(0));
    chk("arst_cerr", 160'(ifc.chn_err), 160'(0));
    chk("arst_cnt", 160'(ifc.err_cnt), 160'(0));
    chk("arst_chn", 160'(ifc.dout_chn), 160'(0));
    chk("arst_data", 160'({ifc.dout_dr, ifc.dout_di}), 160'(0));
    model_reset();
    ifc.sync_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    up = 1;
    adv(10);
    go_to(0);
    step(1, 0, 0);
    up = 1;
    adv(5);

    @(negedge clk);
    chk("sb_drained", 160'(q.size()), 160'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
